mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of all data ports.
REQ-003 Parameter MEM_LATENCY, default 1, legal range 1..4, SHALL be the number of cycles from a read command (mem_en=1, mem_we=0) to valid mem_rdata.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pN_req  input  1  request from port N (N=0 CPU data port, N=1 secondary master); held stable with its fields until pN_gnt.
REQ-007 pN_we  input  1  1 = write, 0 = read.
REQ-008 pN_addr  input  ADDR_W  request address.
REQ-009 pN_wdata  input  DATA_W  write data.
REQ-010 pN_gnt  output  1  one-cycle pulse; the request is accepted this cycle.
REQ-011 pN_rvalid  output  1  one-cycle pulse; pN_rdata holds read data.
REQ-012 pN_rdata  output  DATA_W  read data, valid only while pN_rvalid=1.
REQ-013 mem_en  output  1  memory command strobe.
REQ-014 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data.
REQ-018 busy  output  1  1 while a read is outstanding.

Function
REQ-019 FSM states SHALL be IDLE and RD_WAIT; reset state IDLE.
REQ-020 In IDLE, or in the RD_WAIT cycle that delivers read data, any asserted pN_req SHALL produce exactly one grant that cycle: pN_gnt=1, mem_en=1, and mem_we/mem_addr/mem_wdata driven from the winner.
REQ-021 No grant and no mem_en SHALL occur in any other RD_WAIT cycle.
REQ-022 A granted write SHALL complete in its grant cycle, produce no rvalid, and leave the FSM unchanged.
REQ-023 A read granted in cycle t SHALL enter RD_WAIT, load a latency counter with MEM_LATENCY, and assert pN_rvalid for the granted port only, in cycle t+MEM_LATENCY, with pN_rdata=mem_rdata.
REQ-024 For MEM_LATENCY=1, the read data cycle SHALL be the cycle after grant, allowing back-to-back reads with one grant per cycle.
REQ-025 busy SHALL equal 1 exactly while state is RD_WAIT.
REQ-026 With both requests asserted, the winner SHALL be chosen per REQ-034/REQ-035; the loser SHALL see pN_gnt=0 and keep requesting.
REQ-027 A register last_gnt SHALL record the port of the most recent grant.
REQ-028 pN_rdata SHALL be zero whenever pN_rvalid=0.
REQ-029 A port with no request SHALL never receive gnt or rvalid.

Reset
REQ-030 Asserting reset SHALL immediately force state IDLE, counter 0 and last_gnt=1.
REQ-031 During reset, pN_gnt, pN_rvalid, mem_en, mem_we and busy SHALL be 0.
REQ-032 A read outstanding when reset asserts SHALL be abandoned with no rvalid after reset release.
REQ-033 The first cycle after reset release SHALL be eligible for a grant.

Configuration
REQ-034 With MEM_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the port not equal to last_gnt SHALL win.
REQ-035 Without MEM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests; last_gnt SHALL still be maintained.

Verification
REQ-036 Single write: p0 write addr 0x10, data 0xDEADBEEF -> p0_gnt and mem_en/mem_we in the same cycle, mem_addr=0x10, no rvalid.
REQ-037 Read, MEM_LATENCY=3: p1 read addr 0x20 granted at t, memory returns 0x12345678 at t+3 -> p1_rvalid at t+3 with data 0x12345678, busy during t+1..t+3, no grant during t+1..t+2.
REQ-038 Contention with macro defined: both ports hold read requests for 4 grants -> grants p0,p1,p0,p1; without macro -> p0 every time while p0 requests.
REQ-039 Back-to-back, MEM_LATENCY=1: p0 issues 4 consecutive reads -> 4 grants on consecutive cycles, rvalid one cycle after each.
REQ-040 Reset mid-read: MEM_LATENCY=4, reset asserted at t+2 -> outputs 0 immediately, no rvalid later, grant possible in first cycle after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one of two masters onto a single-ported memory.
// Latency: grant is combinational in an eligible cycle; read data returns MEM_LATENCY cycles after grant.
// Backpressure: losing or blocked requests hold req/fields until gnt; no grants while a read is in flight.
//
// Ports:
//   clk, reset            - single clock, asynchronous active-high reset
//   p0_* / p1_*           - request side (p0 = CPU data port, p1 = secondary master)
//                           req/we/addr/wdata in, gnt/rvalid/rdata out
//   mem_en/we/addr/wdata  - memory command side; mem_rdata returns read data
//   busy                  - high while a read is outstanding (state RD_WAIT)
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate winners on simultaneous
// requests; otherwise port 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;            // cycles left until read data, 1 = data cycle
  logic       last_gnt, last_gnt_nxt;  // port of most recent grant
  logic       rd_port, rd_port_nxt;    // port owning the outstanding read

  logic       rd_done;
  logic       can_grant;
  logic       win;
  logic       sel_we;

  // The data-return cycle of a read is also a grant cycle, so with
  // MEM_LATENCY=1 reads can issue back to back.
  assign rd_done   = (state == RD_WAIT) && (cnt == 3'd1);
  assign can_grant = !reset && ((state == IDLE) || rd_done);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_gnt_nxt = last_gnt;
    rd_port_nxt  = rd_port;
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    win          = 1'b0;
    sel_we       = 1'b0;

    if (state == RD_WAIT) begin
      if (rd_done) begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end else begin
        cnt_nxt   = cnt - 3'd1;
      end
    end

    if (p0_req && p1_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win = ~last_gnt;
`else
      win = 1'b0;
`endif
    end else begin
      win = p1_req;
    end

    if (can_grant && (p0_req || p1_req)) begin
      p0_gnt       = ~win;
      p1_gnt       = win;
      sel_we       = win ? p1_we : p0_we;
      mem_en       = 1'b1;
      mem_we       = sel_we;
      mem_addr     = win ? p1_addr  : p0_addr;
      mem_wdata    = win ? p1_wdata : p0_wdata;
      last_gnt_nxt = win;
      // A write finishes in its grant cycle and leaves the FSM alone.
      if (!sel_we) begin
        state_nxt   = RD_WAIT;
        cnt_nxt     = 3'(MEM_LATENCY);
        rd_port_nxt = win;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      last_gnt <= 1'b1;
      rd_port  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last_gnt <= last_gnt_nxt;
      rd_port  <= rd_port_nxt;
    end
  end

  assign p0_rvalid = !reset && rd_done && !rd_port;
  assign p1_rvalid = !reset && rd_done &&  rd_port;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;
  assign busy      = (state == RD_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Three instances: MEM_LATENCY 1, 3, 4
  logic        rst       [3];
  logic        p0_req    [3];
  logic        p0_we     [3];
  logic [31:0] p0_addr   [3];
  logic [31:0] p0_wdata  [3];
  logic        p0_gnt    [3];
  logic        p0_rvalid [3];
  logic [31:0] p0_rdata  [3];
  logic        p1_req    [3];
  logic        p1_we     [3];
  logic [31:0] p1_addr   [3];
  logic [31:0] p1_wdata  [3];
  logic        p1_gnt    [3];
  logic        p1_rvalid [3];
  logic [31:0] p1_rdata  [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic        busy      [3];

  // Memory contents seen by reads
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h20) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .p0_req    (p0_req[g]),
      .p0_we     (p0_we[g]),
      .p0_addr   (p0_addr[g]),
      .p0_wdata  (p0_wdata[g]),
      .p0_gnt    (p0_gnt[g]),
      .p0_rvalid (p0_rvalid[g]),
      .p0_rdata  (p0_rdata[g]),
      .p1_req    (p1_req[g]),
      .p1_we     (p1_we[g]),
      .p1_addr   (p1_addr[g]),
      .p1_wdata  (p1_wdata[g]),
      .p1_gnt    (p1_gnt[g]),
      .p1_rvalid (p1_rvalid[g]),
      .p1_rdata  (p1_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );

    // Memory model: read command at cycle t returns data during cycle t+L
    logic        pv [4];
    logic [31:0] pd [4];
    initial for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pd[k] = '0; end
    always @(posedge clk) begin
      pv[0] <= mem_en[g] && !mem_we[g];
      pd[0] <= memval(mem_addr[g]);
      for (int k = 1; k < 4; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
    assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 32'h0;
  end

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input int p, input logic [31:0] a, input int c);
    exp_t e;
    e.inst = i; e.port = p; e.data = memval(a); e.cyc = c;
    sbq.push_back(e);
  endtask

  // Scoreboard consumer: every rvalid must match the oldest expected read of that instance
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic        rv;
        logic [31:0] rd;
        int          idx;
        rv  = (p == 0) ? p0_rvalid[i] : p1_rvalid[i];
        rd  = (p == 0) ? p0_rdata[i]  : p1_rdata[i];
        idx = -1;
        if (rv) begin
          for (int k = 0; k < sbq.size(); k++)
            if (sbq[k].inst == i) begin idx = k; break; end
          if (idx < 0) begin
            chk($sformatf("u%0d_p%0d_unexpected_rvalid", i, p), 32'(rv), 32'h0);
          end else begin
            chk($sformatf("u%0d_rvalid_port", i), p, sbq[idx].port);
            chk($sformatf("u%0d_p%0d_rdata", i, p), rd, sbq[idx].data);
            chk($sformatf("u%0d_p%0d_rvalid_cycle", i, p), cyc, sbq[idx].cyc);
            sbq.delete(idx);
          end
        end else begin
          chk($sformatf("u%0d_p%0d_rdata_idle_zero", i, p), rd, 32'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_out(input int i, input string tag, input logic g0, input logic g1,
                         input logic en, input logic we, input logic bsy);
    chk($sformatf("u%0d_%s_p0_gnt", i, tag), 32'(p0_gnt[i]), 32'(g0));
    chk($sformatf("u%0d_%s_p1_gnt", i, tag), 32'(p1_gnt[i]), 32'(g1));
    chk($sformatf("u%0d_%s_mem_en", i, tag), 32'(mem_en[i]), 32'(en));
    chk($sformatf("u%0d_%s_mem_we", i, tag), 32'(mem_we[i]), 32'(we));
    chk($sformatf("u%0d_%s_busy", i, tag),   32'(busy[i]),   32'(bsy));
  endtask

  initial begin
    int t;
    int w;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      p0_req[i] = 1'b0; p0_we[i] = 1'b0; p0_addr[i] = '0; p0_wdata[i] = '0;
      p1_req[i] = 1'b0; p1_we[i] = 1'b0; p1_addr[i] = '0; p1_wdata[i] = '0;
    end
    // Request during reset must not be granted
    p0_req[0] = 1'b1; p0_we[0] = 1'b1;
    tick(); tick(); settle();
    for (int i = 0; i < 3; i++) chk_out(i, "in_reset", 0, 0, 0, 0, 0);
    p0_req[0] = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    settle();
    chk_out(0, "post_reset", 0, 0, 0, 0, 0);

    // Single write on L=1 instance
    tick();
    p0_req[0] = 1'b1; p0_we[0] = 1'b1; p0_addr[0] = 32'h10; p0_wdata[0] = 32'hDEAD_BEEF;
    settle();
    chk_out(0, "wr", 1, 0, 1, 1, 0);
    chk("u0_wr_mem_addr",  mem_addr[0],  32'h10);
    chk("u0_wr_mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    tick();
    p0_req[0] = 1'b0;
    settle();
    chk_out(0, "wr_after", 0, 0, 0, 0, 0);

    // Read with latency 3 on instance 1; p0 waits through RD_WAIT
    tick();
    p1_req[1] = 1'b1; p1_we[1] = 1'b0; p1_addr[1] = 32'h20;
    settle();
    t = cyc;
    chk_out(1, "rd3_gnt", 0, 1, 1, 0, 0);
    chk("u1_rd3_mem_addr", mem_addr[1], 32'h20);
    push(1, 1, 32'h20, t + 3);
    tick();
    p1_req[1] = 1'b0;
    p0_req[1] = 1'b1; p0_we[1] = 1'b0; p0_addr[1] = 32'h30;
    settle();
    chk_out(1, "rd3_wait1", 0, 0, 0, 0, 1);
    tick(); settle();
    chk_out(1, "rd3_wait2", 0, 0, 0, 0, 1);
    tick(); settle();
    chk_out(1, "rd3_data_cycle_gnt", 1, 0, 1, 0, 1);
    chk("u1_rd3b_mem_addr", mem_addr[1], 32'h30);
    push(1, 0, 32'h30, cyc + 3);
    tick();
    p0_req[1] = 1'b0;
    settle();
    chk_out(1, "rd3b_wait1", 0, 0, 0, 0, 1);
    tick(); tick(); settle();
    chk("u1_rd3b_busy_data", 32'(busy[1]), 32'h1);
    tick(); settle();
    chk("u1_rd3b_busy_done", 32'(busy[1]), 32'h0);

    // Contention on latency-4 instance: both ports keep reading
    tick();
    p0_req[2] = 1'b1; p0_we[2] = 1'b0; p0_addr[2] = 32'h40;
    p1_req[2] = 1'b1; p1_we[2] = 1'b0; p1_addr[2] = 32'h44;
    settle();
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = k % 2;
`else
      w = 0;
`endif
      chk_out(2, $sformatf("arb%0d", k), (w == 0), (w == 1), 1, 0, (k != 0));
      push(2, w, (w == 1) ? 32'h44 : 32'h40, cyc + 4);
      if (k < 3) begin
        for (int j = 1; j < 4; j++) begin
          tick(); settle();
          chk_out(2, $sformatf("arb%0d_wait%0d", k, j), 0, 0, 0, 0, 1);
        end
        tick(); settle();
      end else begin
        tick();
        p0_req[2] = 1'b0; p1_req[2] = 1'b0;
        settle();
        chk_out(2, "arb_end", 0, 0, 0, 0, 1);
      end
    end

    // Back-to-back reads with latency 1
    tick();
    for (int k = 0; k < 4; k++) begin
      p0_req[0] = 1'b1; p0_we[0] = 1'b0; p0_addr[0] = 32'h100 + 32'(4 * k);
      settle();
      chk_out(0, $sformatf("b2b%0d", k), 1, 0, 1, 0, (k != 0));
      chk($sformatf("u0_b2b%0d_mem_addr", k), mem_addr[0], 32'h100 + 32'(4 * k));
      push(0, 0, 32'h100 + 32'(4 * k), cyc + 1);
      tick();
    end
    p0_req[0] = 1'b0;
    settle();
    chk_out(0, "b2b_last_data", 0, 0, 0, 0, 1);
    tick(); settle();
    chk("u0_b2b_idle_busy", 32'(busy[0]), 32'h0);

    // Reset in the middle of a latency-4 read
    tick(); settle();
    chk("u2_pre_rst_idle", 32'(busy[2]), 32'h0);
    tick();
    p0_req[2] = 1'b1; p0_we[2] = 1'b0; p0_addr[2] = 32'h200;
    settle();
    chk_out(2, "rst_rd_gnt", 1, 0, 1, 0, 0);
    tick();
    p0_req[2] = 1'b0;
    settle();
    chk_out(2, "rst_rd_wait", 0, 0, 0, 0, 1);
    tick();
    rst[2] = 1'b1;
    p1_req[2] = 1'b1; p1_we[2] = 1'b1; p1_addr[2] = 32'h300; p1_wdata[2] = 32'hCAFE_0001;
    settle();
    chk_out(2, "rst_mid", 0, 0, 0, 0, 0);
    tick(); settle();
    chk_out(2, "rst_hold", 0, 0, 0, 0, 0);
    tick();
    rst[2] = 1'b0;
    settle();
    chk_out(2, "rst_release_gnt", 0, 1, 1, 1, 0);
    chk("u2_rst_release_addr", mem_addr[2], 32'h300);
    tick();
    p1_req[2] = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    settle();
    chk_out(2, "rst_after", 0, 0, 0, 0, 0);

    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
